ifu_pc_gen: RTL and testbench

//  Fetch-PC generator directly upstream of the next-line predictor (NLP). Holds the IF0 fetch PC
//  (a pair of words: PC, PC+4) and drives it to the NLP. Consumes the same-cycle NLP lookup

---
 rtl/ifu_pc_gen_if.sv | 34 +++
 rtl/ifu_pc_gen.sv | 144 ++++++++++++++
 tb/tb_ifu_pc_gen.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ifu_pc_gen_if.sv
// Fetch-PC generator port bundle: redirects, NLP lookup results and fetch PC/prediction outputs.
// The slave modport is the PC generator; the master modport is its environment.
interface ifu_pc_gen_if;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] flush_pc_i;
   logic        if3_redir_i;
   logic [31:0] if3_redir_pc_i;
   logic        nlp0_valid_i;
   logic        nlp0_taken_i;
   logic [31:0] nlp0_target_i;
   logic        nlp1_valid_i;
   logic        nlp1_taken_i;
   logic [31:0] nlp1_target_i;
   logic [31:0] pc_o;
   logic        pc_valid_o;
   logic [1:0]  slot_valid_o;
   logic [1:0]  pred_taken_o;
   logic [31:0] pred_target_o;

   modport slave (
      input  stall_i, flush_i, flush_pc_i, if3_redir_i, if3_redir_pc_i,
      input  nlp0_valid_i, nlp0_taken_i, nlp0_target_i,
      input  nlp1_valid_i, nlp1_taken_i, nlp1_target_i,
      output pc_o, pc_valid_o, slot_valid_o, pred_taken_o, pred_target_o
   );

   modport master (
      output stall_i, flush_i, flush_pc_i, if3_redir_i, if3_redir_pc_i,
      output nlp0_valid_i, nlp0_taken_i, nlp0_target_i,
      output nlp1_valid_i, nlp1_taken_i, nlp1_target_i,
      input  pc_o, pc_valid_o, slot_valid_o, pred_taken_o, pred_target_o
   );
endinterface

// File: rtl/ifu_pc_gen.sv
// IF0 fetch-PC generator: holds the PC pair, picks the next PC from redirects and same-cycle
// NLP results, and inserts a single-word delay-slot fetch when only the second word predicts taken.
module ifu_pc_gen #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input logic          clk,
   input logic          rst_n,
   ifu_pc_gen_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_DS   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_held;
   logic        r_pc_valid;
   logic [1:0]  r_slot_valid;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_held_nxt;
   logic        w_pc_valid_nxt;
   logic [1:0]  w_slot_valid_nxt;
   logic        w_fire;
   logic        w_p0;
   logic        w_p1;
   logic [31:0] w_pc_plus8;
   logic [1:0]  w_pred_taken;
   logic [31:0] w_pred_target;

   assign w_fire     = r_pc_valid & ~bus.stall_i;
   assign w_p0       = bus.nlp0_valid_i & bus.nlp0_taken_i;
   assign w_p1       = bus.nlp1_valid_i & bus.nlp1_taken_i;
   assign w_pc_plus8 = r_pc + 32'd8;

   // Next PC / state / held target; redirects override everything, including stalls and BOOT.
   always_comb begin
      w_pc_nxt    = r_pc;
      w_state_nxt = r_state;
      w_held_nxt  = r_held;
      if (bus.flush_i) begin
         w_pc_nxt    = bus.flush_pc_i;
         w_state_nxt = ST_RUN;
         w_held_nxt  = 32'd0;
      end else if (bus.if3_redir_i) begin
         w_pc_nxt    = bus.if3_redir_pc_i;
         w_state_nxt = ST_RUN;
         w_held_nxt  = 32'd0;
      end else if (w_fire) begin
         case (r_state)
            ST_DS: begin
               w_pc_nxt    = r_held;
               w_state_nxt = ST_RUN;
               w_held_nxt  = 32'd0;
            end
            ST_RUN: begin
               if (w_p0) begin
                  // Delay slot of a slot-0 branch is word 1 of this same pair.
                  w_pc_nxt = bus.nlp0_target_i;
               end else if (w_p1) begin
                  w_pc_nxt    = w_pc_plus8;
                  w_held_nxt  = bus.nlp1_target_i;
                  w_state_nxt = ST_DS;
               end else begin
                  w_pc_nxt = w_pc_plus8;
               end
            end
            default: begin
               w_pc_nxt    = r_pc;
               w_state_nxt = r_state;
               w_held_nxt  = r_held;
            end
         endcase
      end else if (r_state == ST_BOOT) begin
         w_state_nxt = ST_RUN;
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Fetch-valid and slot-valid follow the next state so they can be registered.
   always_comb begin
      w_pc_valid_nxt   = 1'b0;
      w_slot_valid_nxt = 2'b00;
      case (w_state_nxt)
         ST_RUN: begin
            w_pc_valid_nxt   = 1'b1;
            w_slot_valid_nxt = 2'b11;
         end
         ST_DS: begin
            w_pc_valid_nxt   = 1'b1;
            w_slot_valid_nxt = 2'b01;
         end
         default: begin
            w_pc_valid_nxt   = 1'b0;
            w_slot_valid_nxt = 2'b00;
         end
      endcase
   end

   // Fetch FSM state, PC, held delay-slot target and registered fetch qualifiers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_BOOT;
         r_pc         <= RESET_PC;
         r_held       <= 32'd0;
         r_pc_valid   <= 1'b0;
         r_slot_valid <= 2'b00;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_held       <= w_held_nxt;
         r_pc_valid   <= w_pc_valid_nxt;
         r_slot_valid <= w_slot_valid_nxt;
      end
   end

   // Per-slot prediction, only trusted in RUN; slot 0 target wins when both predict taken.
   always_comb begin
      w_pred_target = 32'd0;
      if (r_state == ST_RUN) begin
         w_pred_taken = {w_p1, w_p0} & r_slot_valid;
      end else begin
         w_pred_taken = 2'b00;
      end
      if (w_pred_taken[0]) begin
         w_pred_target = bus.nlp0_target_i;
      end else if (w_pred_taken[1]) begin
         w_pred_target = bus.nlp1_target_i;
      end else begin
         w_pred_target = 32'd0;
      end
   end

   assign bus.pc_o          = r_pc;
   assign bus.pc_valid_o    = r_pc_valid;
   assign bus.slot_valid_o  = r_slot_valid;
   assign bus.pred_taken_o  = w_pred_taken;
   assign bus.pred_target_o = w_pred_target;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Directed bench for ifu_pc_gen: boot sequence, NLP predictions, delay slot, stalls,
// redirect priority, PC wraparound and asynchronous reset.
module tb_ifu_pc_gen;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   ifu_pc_gen_if u_if ();

   ifu_pc_gen #(.RESET_PC(32'hBFC0_0000)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_fetch(input string tag, input logic [31:0] pc, input logic vld,
                            input logic [1:0] slot);
      chk({tag, "_pc"}, u_if.pc_o, pc);
      chk({tag, "_valid"}, {31'd0, u_if.pc_valid_o}, {31'd0, vld});
      chk({tag, "_slot"}, {30'd0, u_if.slot_valid_o}, {30'd0, slot});
   endtask

   task automatic chk_pred(input string tag, input logic [1:0] taken, input logic [31:0] tgt);
      chk({tag, "_ptaken"}, {30'd0, u_if.pred_taken_o}, {30'd0, taken});
      chk({tag, "_ptarget"}, u_if.pred_target_o, tgt);
   endtask

   task automatic clear_nlp();
      u_if.nlp0_valid_i  = 1'b0;
      u_if.nlp0_taken_i  = 1'b0;
      u_if.nlp0_target_i = 32'd0;
      u_if.nlp1_valid_i  = 1'b0;
      u_if.nlp1_taken_i  = 1'b0;
      u_if.nlp1_target_i = 32'd0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      u_if.stall_i        = 1'b0;
      u_if.flush_i        = 1'b0;
      u_if.flush_pc_i     = 32'd0;
      u_if.if3_redir_i    = 1'b0;
      u_if.if3_redir_pc_i = 32'd0;
      clear_nlp();

      repeat (2) @(negedge clk);
      chk_fetch("reset", 32'hBFC0_0000, 1'b0, 2'b00);
      rst_n = 1'b1;
      #1 chk_fetch("boot", 32'hBFC0_0000, 1'b0, 2'b00);

      @(negedge clk);
      chk_fetch("run0", 32'hBFC0_0000, 1'b1, 2'b11);
      chk_pred("run0", 2'b00, 32'd0);
      @(negedge clk);
      chk_fetch("run1", 32'hBFC0_0008, 1'b1, 2'b11);
      @(negedge clk);
      chk_fetch("run2", 32'hBFC0_0010, 1'b1, 2'b11);

      // slot-0 taken
      u_if.nlp0_valid_i  = 1'b1;
      u_if.nlp0_taken_i  = 1'b1;
      u_if.nlp0_target_i = 32'h8000_0100;
      #1 chk_pred("p0", 2'b01, 32'h8000_0100);
      @(negedge clk);
      chk_fetch("p0_next", 32'h8000_0100, 1'b1, 2'b11);
      clear_nlp();

      // back to BFC00010 via IF3 redirect, then slot-1 taken only
      u_if.if3_redir_i    = 1'b1;
      u_if.if3_redir_pc_i = 32'hBFC0_0010;
      @(negedge clk);
      chk_fetch("if3", 32'hBFC0_0010, 1'b1, 2'b11);
      u_if.if3_redir_i   = 1'b0;
      u_if.nlp0_valid_i  = 1'b1;
      u_if.nlp0_target_i = 32'h1111_1110;
      u_if.nlp1_valid_i  = 1'b1;
      u_if.nlp1_taken_i  = 1'b1;
      u_if.nlp1_target_i = 32'h8000_0200;
      #1 chk_pred("p1", 2'b10, 32'h8000_0200);
      @(negedge clk);
      chk_fetch("ds", 32'hBFC0_0018, 1'b1, 2'b01);
      chk_pred("ds", 2'b00, 32'd0);

      // stall three cycles in DS
      u_if.stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_fetch($sformatf("ds_stall%0d", i), 32'hBFC0_0018, 1'b1, 2'b01);
      end
      u_if.stall_i = 1'b0;
      @(negedge clk);
      chk_fetch("ds_exit", 32'h8000_0200, 1'b1, 2'b11);
      clear_nlp();

      // re-enter DS, then simultaneous flush and IF3 redirect
      u_if.if3_redir_i    = 1'b1;
      u_if.if3_redir_pc_i = 32'hBFC0_0010;
      @(negedge clk);
      u_if.if3_redir_i   = 1'b0;
      u_if.nlp1_valid_i  = 1'b1;
      u_if.nlp1_taken_i  = 1'b1;
      u_if.nlp1_target_i = 32'h8000_0200;
      @(negedge clk);
      chk_fetch("ds2", 32'hBFC0_0018, 1'b1, 2'b01);
      clear_nlp();
      u_if.flush_i        = 1'b1;
      u_if.flush_pc_i     = 32'h8000_1000;
      u_if.if3_redir_i    = 1'b1;
      u_if.if3_redir_pc_i = 32'h1234_5678;
      @(negedge clk);
      chk_fetch("flush_wins", 32'h8000_1000, 1'b1, 2'b11);
      u_if.flush_i     = 1'b0;
      u_if.if3_redir_i = 1'b0;
      @(negedge clk);
      chk_fetch("held_dropped", 32'h8000_1008, 1'b1, 2'b11);

      // flush while stalled, then wraparound
      u_if.stall_i    = 1'b1;
      u_if.flush_i    = 1'b1;
      u_if.flush_pc_i = 32'hFFFF_FFF8;
      @(negedge clk);
      chk_fetch("flush_stall", 32'hFFFF_FFF8, 1'b1, 2'b11);
      u_if.stall_i = 1'b0;
      u_if.flush_i = 1'b0;
      @(negedge clk);
      chk_fetch("wrap", 32'h0000_0000, 1'b1, 2'b11);

      // both slots taken: slot 0 wins
      u_if.nlp0_valid_i  = 1'b1;
      u_if.nlp0_taken_i  = 1'b1;
      u_if.nlp0_target_i = 32'hA000_0000;
      u_if.nlp1_valid_i  = 1'b1;
      u_if.nlp1_taken_i  = 1'b1;
      u_if.nlp1_target_i = 32'hB000_0000;
      #1 chk_pred("both", 2'b11, 32'hA000_0000);
      @(negedge clk);
      chk_fetch("both_next", 32'hA000_0000, 1'b1, 2'b11);

      // enter DS, then asynchronous reset mid-operation
      u_if.nlp0_taken_i = 1'b0;
      @(negedge clk);
      chk_fetch("ds3", 32'hA000_0008, 1'b1, 2'b01);
      clear_nlp();
      rst_n = 1'b0;
      #1 chk_fetch("async_rst", 32'hBFC0_0000, 1'b0, 2'b00);

      // redirect during BOOT
      @(negedge clk);
      rst_n           = 1'b1;
      u_if.flush_i    = 1'b1;
      u_if.flush_pc_i = 32'h8000_2000;
      @(negedge clk);
      chk_fetch("boot_flush", 32'h8000_2000, 1'b1, 2'b11);
      u_if.flush_i = 1'b0;
      @(negedge clk);
      chk_fetch("boot_flush_next", 32'h8000_2008, 1'b1, 2'b11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
